// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO: word width, entry count and pointer index width.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_ADDR  = 3;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// FIFO storage array: DEPTH x WIDTH words, clocked write port, combinational read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int ADDR  = FIFO_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ADDR-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ADDR-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Reset wipes every entry so a flushed queue never shows stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/fifo_top_sync.sv
// Single-clock show-ahead FIFO: wrap-bit pointers, flags decoded from registered pointers only.
module fifo_top_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int ADDR  = FIFO_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rinc,
    output logic [WIDTH-1:0] rdata,
    output logic             wfull,
    output logic             rempty
);

    localparam logic [ADDR:0] PTR_ONE = {{ADDR{1'b0}}, 1'b1};

    logic [ADDR:0] wptr;
    logic [ADDR:0] rptr;
    logic          wr_en;
    logic          rd_en;

    // Requests are qualified only by flags from the current pointers, so a
    // same-cycle read never lets a write into a full queue (and vice versa).
    assign wr_en = winc & ~wfull;
    assign rd_en = rinc & ~rempty;

    // Pointer registers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_en) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Flag decode from registered pointers.
    assign rempty = (wptr == rptr);
    assign wfull  = (wptr[ADDR] != rptr[ADDR]) &&
                    (wptr[ADDR-1:0] == rptr[ADDR-1:0]);

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wptr[ADDR-1:0]),
        .wdata (wdata),
        .raddr (rptr[ADDR-1:0]),
        .rdata (rdata)
    );

endmodule : fifo_top_sync

// File: tb/tb_fifo_top_sync.sv
// Bench for fifo_top_sync: directed scenarios plus random traffic against a queue model.
module tb_fifo_top_sync;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int ADDR  = 3;

    logic             clk;
    logic             rst;
    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             rinc;
    logic [WIDTH-1:0] rdata;
    logic             wfull;
    logic             rempty;

    int checks   = 0;
    int failures = 0;

    int model_q[$];
    int out_log[$];

    fifo_top_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .winc   (winc),
        .wdata  (wdata),
        .rinc   (rinc),
        .rdata  (rdata),
        .wfull  (wfull),
        .rempty (rempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the queue model, check outputs after the edge.
    task automatic step(input logic r, input logic w, input int wd, input logic rd, input string tag);
        bit wr_ok;
        bit rd_ok;
        rst   = r;
        winc  = w;
        wdata = wd[WIDTH-1:0];
        rinc  = rd;
        wr_ok = !r && w && (model_q.size() < DEPTH);
        rd_ok = !r && rd && (model_q.size() > 0);
        if (rd_ok) out_log.push_back(int'(rdata));
        @(posedge clk);
        #1;
        if (r) begin
            model_q.delete();
        end else begin
            if (rd_ok) void'(model_q.pop_front());
            if (wr_ok) model_q.push_back(wd & 8'hFF);
        end
        chk({tag, ":rempty"}, 32'(rempty), 32'(model_q.size() == 0));
        chk({tag, ":wfull"},  32'(wfull),  32'(model_q.size() == DEPTH));
        if (model_q.size() > 0) chk({tag, ":rdata"}, 32'(rdata), 32'(model_q[0]));
    endtask

    int fill_seq[8]  = '{77, 79, 72, 65, 77, 77, 69, 68};
    int wrap_seq[14] = '{79, 114, 105, 103, 105, 110, 97, 108, 95, 70, 73, 70, 73, 73};

    initial begin
        rst = 1'b1; winc = 1'b0; wdata = '0; rinc = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 0, 1'b0, "reset");
        chk("reset:rdata_zero", 32'(rdata), 32'd0);
        step(1'b0, 1'b0, 0, 1'b0, "idle");

        // Fill to full, then an ignored ninth write
        foreach (fill_seq[i]) step(1'b0, 1'b1, fill_seq[i], 1'b0, "fill");
        chk("fill:full_after_8", 32'(wfull), 32'd1);
        step(1'b0, 1'b1, 100, 1'b0, "write_when_full");
        chk("full:head_kept", 32'(rdata), 32'd77);

        // Drain in order, then a ninth read on empty
        out_log.delete();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, 1'b1, "drain");
        chk("drain:count", 32'(out_log.size()), 32'd8);
        foreach (fill_seq[i]) chk("drain:order", 32'(out_log[i]), 32'(fill_seq[i]));
        step(1'b0, 1'b0, 0, 1'b1, "read_when_empty");
        step(1'b0, 1'b1, 55, 1'b0, "write_after_empty");
        chk("first_write_visible", 32'(rdata), 32'd55);
        step(1'b0, 1'b0, 0, 1'b1, "drain55");

        // Simultaneous read/write with three entries held
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10 + i, 1'b0, "pre3");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 20 + i, 1'b1, "rw3");
        chk("rw3:occupancy", 32'(model_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, "post3");

        // Streaming across pointer wrap
        out_log.delete();
        foreach (wrap_seq[i]) step(1'b0, 1'b1, wrap_seq[i], 1'b1, "stream");
        step(1'b0, 1'b0, 0, 1'b1, "stream_tail");
        chk("stream:count", 32'(out_log.size()), 32'd14);
        foreach (wrap_seq[i]) chk("stream:order", 32'(out_log[i]), 32'(wrap_seq[i]));
        chk("stream:empty_end", 32'(rempty), 32'd1);

        // Reset while holding five entries
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 200 + i, 1'b0, "hold5");
        step(1'b1, 1'b0, 0, 1'b0, "reset5");
        chk("reset5:rdata_zero", 32'(rdata), 32'd0);
        step(1'b0, 1'b1, 42, 1'b0, "post_reset_write");
        chk("post_reset:new_data", 32'(rdata), 32'd42);
        step(1'b0, 1'b0, 0, 1'b1, "post_reset_read");

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_top_sync

// File: doc/fifo_top_sync.md
FIFO_TOP_SYNC -- requirements
Module: fifo_top_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of storage entries.
REQ-003 SHALL have parameter ADDR, default 3: address width, with DEPTH == 2**ADDR.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port: winc  input  1  write request.
REQ-008 SHALL have port: wdata  input  WIDTH  write data.
REQ-009 SHALL have port: rinc  input  1  read request.
REQ-010 SHALL have port: rdata  output  WIDTH  head-of-queue data.
REQ-011 SHALL have port: wfull  output  1  FIFO holds DEPTH entries.
REQ-012 SHALL have port: rempty  output  1  FIFO holds zero entries.

Function
REQ-013 SHALL keep write and read pointers of ADDR+1 bits; the low ADDR bits index the memory, and the MSB is a wrap bit.
REQ-014 SHALL perform a write (mem[wptr] <= wdata; wptr++) at a clk edge when winc=1 and wfull=0.
REQ-015 SHALL perform a read (rptr++) at a clk edge when rinc=1 and rempty=0.
REQ-016 SHALL ignore winc while wfull=1, leaving memory and wptr unchanged, even if a read occurs in the same cycle.
REQ-017 SHALL ignore rinc while rempty=1, leaving rptr unchanged, even if a write occurs in the same cycle.
REQ-018 SHALL allow a write and a read in the same cycle when neither is blocked, leaving occupancy unchanged.
REQ-019 SHALL drive rempty=1 exactly when wptr == rptr (all ADDR+1 bits).
REQ-020 SHALL drive wfull=1 exactly when the pointer MSBs differ and the low ADDR bits are equal.
REQ-021 SHALL derive both flags from registered pointers only, so each flag is valid in the cycle after the causing edge, with no combinational path from winc/rinc.
REQ-022 SHALL drive rdata = mem[rptr[ADDR-1:0]] in show-ahead mode: the oldest entry is visible while rempty=0, and the next entry appears the cycle after a read.
REQ-023 SHALL treat rdata as don't-care while rempty=1.
REQ-024 SHALL wrap pointers modulo 2*DEPTH, so data order is preserved across any number of wraps.
REQ-025 SHALL guarantee the first write after empty is visible on rdata, with rempty=0, one cycle after the write edge.

Reset
REQ-026 SHALL clear wptr and rptr to 0 at a clk edge with rst=1.
REQ-027 SHALL give rempty=1 and wfull=0 in the cycle after reset.
REQ-028 SHALL clear all memory entries to 0 on reset, so rdata=0 after reset.
REQ-029 SHALL give reset priority over winc/rinc, so a reset mid-operation discards all stored data.

Structure
REQ-030 SHALL place default WIDTH/DEPTH/ADDR constants in a shared package, fifo_pkg.
REQ-031 SHALL place storage in one sub-module, fifo_mem: DEPTH x WIDTH, synchronous write, asynchronous read.
REQ-032 SHALL keep pointer and flag logic in fifo_top_sync.

Verification
REQ-033 SHALL cover: assert rst for one cycle -> rempty=1, wfull=0, rdata=0.
REQ-034 SHALL cover: write 77,79,72,65,77,77,69,68 -> wfull=1 after the 8th write; a 9th write of 100 is ignored.
REQ-035 SHALL cover: from full, assert rinc for 8 cycles -> rdata sequence 77,79,72,65,77,77,69,68, then rempty=1; a 9th read leaves rptr unchanged.
REQ-036 SHALL cover: simultaneous winc and rinc with 3 entries stored -> occupancy stays 3, order preserved, no flag change.
REQ-037 SHALL cover: write 14 bytes 79,114,105,103,105,110,97,108,95,70,73,70,73,73 while continuously reading -> output equals input order across pointer wrap, and rempty=1 at end.
REQ-038 SHALL cover: assert rst while holding 5 entries -> next cycle rempty=1, wfull=0, and a subsequent write/read returns only the new data.
